// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg: one-hot instruction classes shared by LSU/WBU and the LSU state encoding
package ysyx_25020047_pkg;
  localparam logic [31:0] INST_ADDI = 32'h0000_0001;
  localparam logic [31:0] INST_LW   = 32'h0000_0020;
  localparam logic [31:0] INST_LBU  = 32'h0000_0040;
  localparam logic [31:0] INST_SW   = 32'h0000_0080;
  localparam logic [31:0] INST_SB   = 32'h0000_0100;
  localparam logic [31:0] INST_AND  = 32'h0010_0000;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_t;
endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// ysyx_25020047_lsu_align: byte-lane steering for stores and load extraction
module ysyx_25020047_lsu_align
  import ysyx_25020047_pkg::*;
(
  input  logic [31:0] inst_type,
  input  logic [1:0]  addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);
  logic [7:0] rbyte;
  always_comb begin
    rbyte      = 8'(mem_rdata >> {addr, 3'b000});
    load_data  = inst_type == INST_LW ? mem_rdata : inst_type == INST_LBU ? {24'b0, rbyte} : '0;
    wmask      = inst_type == INST_SW ? 4'hF : inst_type == INST_SB ? 4'b0001 << addr : 4'h0;
    wdata      = inst_type == INST_SW ? store_data : inst_type == INST_SB ? {4{store_data[7:0]}} : '0;
    misaligned = inst_type == INST_LW && addr != 2'b00;
  end
endmodule

// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: multi-cycle load/store unit with valid/ready handshakes on all sides
module ysyx_25020047_lsu
  import ysyx_25020047_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst_type,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] memdata,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  lsu_state_t state;
  logic [31:0] inst_q;
  logic [1:0]  off_q;
  logic [CW-1:0] cnt;
  logic        idle;
  logic        is_mem;
  logic [31:0] a_inst;
  logic [1:0]  a_off;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        misaligned;
  assign idle      = state == S_IDLE;
  assign in_ready  = idle;
  assign mem_valid = state == S_REQ;
  assign out_valid = state == S_RESP;
  assign is_mem    = inst_type inside {INST_LW, INST_LBU, INST_SW, INST_SB};
  // Live inputs steer the aligner only in IDLE; store lanes are registered there so outputs never see inputs
  assign a_inst    = idle ? inst_type : inst_q;
  assign a_off     = idle ? result[1:0] : off_q;
  ysyx_25020047_lsu_align u_align (
    .inst_type (a_inst),
    .addr      (a_off),
    .store_data(store_data),
    .mem_rdata (mem_rdata),
    .wmask     (wmask),
    .wdata     (wdata),
    .load_data (load_data),
    .misaligned(misaligned)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      inst_q    <= '0;
      off_q     <= '0;
      cnt       <= '0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      memdata   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          inst_q    <= inst_type;
          off_q     <= result[1:0];
          mem_addr  <= {result[31:2], 2'b00};
          mem_wdata <= wdata;
          mem_wmask <= wmask;
          mem_wen   <= inst_type == INST_SW || inst_type == INST_SB;
          memdata   <= '0;
          err       <= misaligned;
          state     <= is_mem && !misaligned ? S_REQ : S_RESP;
        end
        S_REQ: if (mem_ready) begin
          cnt <= '0;
          if (mem_rvalid) memdata <= load_data;
          state <= mem_rvalid ? S_RESP : S_WAIT;
        end
        S_WAIT: if (mem_rvalid) begin
          memdata <= load_data;
          state   <= S_RESP;
        end else if (cnt == CW'(TIMEOUT)) begin
          memdata <= '0;
          err     <= 1'b1;
          state   <= S_RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_RESP: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb_ysyx_25020047_lsu: directed self-checking bench for the LSU (TIMEOUT=4)
module tb_ysyx_25020047_lsu;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready;
  logic [31:0] inst_type = 0, result = 0, store_data = 0;
  logic mem_valid, mem_ready = 0, mem_wen, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0] mem_wmask;
  logic out_valid, out_ready = 0, err;
  logic [31:0] memdata;
  int total = 0, bad = 0;

  ysyx_25020047_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .result(result), .store_data(store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .memdata(memdata), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total++; if ({in_ready, mem_valid, out_valid, err, mem_wen} !== 5'b10000) begin bad++; $display("FAIL reset_ctrl got %b exp 10000", {in_ready, mem_valid, out_valid, err, mem_wen}); end
    total++; if ({mem_addr, mem_wdata, memdata, mem_wmask} !== 100'h0) begin bad++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, memdata, mem_wmask}); end
    tick; tick;
    rst = 0;
  endtask

  task automatic test_lbu;
    in_valid = 1; inst_type = 32'h40; result = 32'h8000_0003; store_data = 32'hFFFF_FFFF;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hAABB_CCDD;
    tick;
    in_valid = 0;
    total++; if ({mem_valid, mem_wen, mem_wmask, out_valid} !== 7'b1000000) begin bad++; $display("FAIL lbu_req got %b exp 1000000", {mem_valid, mem_wen, mem_wmask, out_valid}); end
    total++; if (mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL lbu_addr got %h exp 80000000", mem_addr); end
    tick;
    mem_ready = 0; mem_rvalid = 0;
    total++; if ({out_valid, err, in_ready} !== 3'b100) begin bad++; $display("FAIL lbu_resp got %b exp 100", {out_valid, err, in_ready}); end
    total++; if (memdata !== 32'h0000_00AA) begin bad++; $display("FAIL lbu_data got %h exp 000000aa", memdata); end
    out_ready = 1;
    tick;
    out_ready = 0;
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL lbu_idle got %b exp 10", {in_ready, out_valid}); end
  endtask

  task automatic test_sb;
    in_valid = 1; inst_type = 32'h100; result = 32'h8000_0101; store_data = 32'h1234_5678;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick;
    in_valid = 0;
    total++; if ({mem_valid, mem_wen, mem_wmask} !== 6'b110010) begin bad++; $display("FAIL sb_req got %b exp 110010", {mem_valid, mem_wen, mem_wmask}); end
    total++; if (mem_wdata !== 32'h7878_7878) begin bad++; $display("FAIL sb_wdata got %h exp 78787878", mem_wdata); end
    total++; if (mem_addr !== 32'h8000_0100) begin bad++; $display("FAIL sb_addr got %h exp 80000100", mem_addr); end
    tick;
    mem_ready = 0; mem_rvalid = 0;
    total++; if ({out_valid, err, memdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL sb_resp got %b/%b/%h exp 1/0/0", out_valid, err, memdata); end
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  task automatic test_misaligned;
    in_valid = 1; inst_type = 32'h20; result = 32'h8000_0002;
    tick;
    in_valid = 0;
    total++; if ({out_valid, err, mem_valid} !== 3'b110) begin bad++; $display("FAIL mis_resp got %b exp 110", {out_valid, err, mem_valid}); end
    total++; if (memdata !== 32'h0) begin bad++; $display("FAIL mis_data got %h exp 0", memdata); end
    out_ready = 1;
    tick;
    out_ready = 0;
    total++; if ({in_ready, mem_valid} !== 2'b10) begin bad++; $display("FAIL mis_idle got %b exp 10", {in_ready, mem_valid}); end
  endtask

  task automatic test_stall;
    in_valid = 1; inst_type = 32'h20; result = 32'h8000_0010; store_data = 32'h0BAD_F00D;
    mem_ready = 0; mem_rvalid = 0;
    tick;
    in_valid = 0; result = 32'h0; inst_type = 32'h80;
    for (int i = 0; i < 4; i++) begin
      total++; if ({mem_valid, mem_wen, mem_wmask, mem_addr} !== {6'b100000, 32'h8000_0010}) begin bad++; $display("FAIL stall_req%0d got %b/%b/%h/%h exp 1/0/0/80000010", i, mem_valid, mem_wen, mem_wmask, mem_addr); end
      if (i == 3) mem_ready = 1;
      tick;
    end
    mem_ready = 0;
    total++; if ({mem_valid, out_valid} !== 2'b00) begin bad++; $display("FAIL stall_wait1 got %b exp 00", {mem_valid, out_valid}); end
    tick;
    mem_rvalid = 1; mem_rdata = 32'h1122_3344;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_wait2 got %b exp 0", out_valid); end
    tick;
    mem_rvalid = 0; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      total++; if ({out_valid, in_ready, err, memdata} !== {3'b100, 32'h1122_3344}) begin bad++; $display("FAIL stall_resp%0d got %b/%b/%b/%h exp 1/0/0/11223344", i, out_valid, in_ready, err, memdata); end
      tick;
    end
    out_ready = 1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_hs got %b exp 0", in_ready); end
    tick;
    out_ready = 0;
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL stall_idle got %b exp 10", {in_ready, out_valid}); end
  endtask

  task automatic test_timeout;
    in_valid = 1; inst_type = 32'h20; result = 32'h8000_0020;
    mem_ready = 1; mem_rvalid = 0;
    tick;
    in_valid = 0;
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL to_req got %b exp 1", mem_valid); end
    tick;
    mem_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL to_early%0d got %b exp 0", i, out_valid); end
    end
    tick;
    total++; if ({out_valid, err, memdata} !== {2'b11, 32'h0}) begin bad++; $display("FAIL to_resp got %b/%b/%h exp 1/1/0", out_valid, err, memdata); end
    mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    tick;
    total++; if ({out_valid, err, memdata} !== {2'b11, 32'h0}) begin bad++; $display("FAIL to_late got %b/%b/%h exp 1/1/0", out_valid, err, memdata); end
    out_ready = 1;
    tick;
    out_ready = 0;
    tick;
    mem_rvalid = 0;
    total++; if ({in_ready, out_valid, mem_valid} !== 3'b100) begin bad++; $display("FAIL to_idle got %b exp 100", {in_ready, out_valid, mem_valid}); end
  endtask

  task automatic test_reset_mid;
    in_valid = 1; inst_type = 32'h20; result = 32'h8000_0030;
    mem_ready = 1; mem_rvalid = 0;
    tick;
    in_valid = 0;
    tick;
    mem_ready = 0;
    #1 rst = 1;
    #1;
    total++; if ({in_ready, mem_valid, out_valid, err} !== 4'b1000) begin bad++; $display("FAIL rmid_ctrl got %b exp 1000", {in_ready, mem_valid, out_valid, err}); end
    total++; if ({mem_addr, memdata} !== 64'h0) begin bad++; $display("FAIL rmid_data got %h exp 0", {mem_addr, memdata}); end
    #1 rst = 0;
    tick;
    in_valid = 1; inst_type = 32'h1; result = 32'h0000_1234;
    tick;
    in_valid = 0;
    total++; if ({out_valid, err, mem_valid, memdata} !== {3'b100, 32'h0}) begin bad++; $display("FAIL rmid_addi got %b/%b/%b/%h exp 1/0/0/0", out_valid, err, mem_valid, memdata); end
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  task automatic test_back_to_back;
    int nresp;
    nresp = 0;
    in_valid = 1; inst_type = 32'h80; result = 32'h8000_0004; store_data = 32'hCAFE_BABE;
    mem_ready = 1; mem_rvalid = 1; out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (out_valid) nresp++;
      if (mem_valid) begin
        total++; if ({mem_wen, mem_wmask, mem_wdata} !== {5'b11111, 32'hCAFE_BABE}) begin bad++; $display("FAIL b2b_sw got %b/%b/%h exp 1/1111/cafebabe", mem_wen, mem_wmask, mem_wdata); end
      end
    end
    total++; if (nresp !== 3) begin bad++; $display("FAIL b2b_mem got %0d exp 3", nresp); end
    in_valid = 0; mem_ready = 0; mem_rvalid = 0;
    tick;
    nresp = 0;
    in_valid = 1; inst_type = 32'h1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (out_valid) nresp++;
    end
    total++; if (nresp !== 3) begin bad++; $display("FAIL b2b_nonmem got %0d exp 3", nresp); end
    in_valid = 0;
    tick;
    out_ready = 0;
  endtask

  initial begin
    test_reset;
    tick;
    test_lbu;
    test_sb;
    test_misaligned;
    test_stall;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
